memory_sequencer: RTL
=====================

MEMORY_SEQUENCER -- requirements
Module: memory_sequencer

Interface
REQ-001 SHALL have parameter INITIAL_MEM_CONTENTS, default "initialRam.mem": RAM init file.
REQ-002 SHALL have parameter RAM_A_WIDTH, default 12: RAM word-address bits (2^RAM_A_WIDTH words).
REQ-003 SHALL have parameter MMIO_CHANNELS, default 8, power of two from 1 to 64: MMIO word count per direction.
REQ-004 clock  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 reqValid  in  1  request present.
REQ-007 reqReady  out  1  sequencer can accept; request taken when reqValid && reqReady.
REQ-008 reqStore  in  1  1 = store, 0 = load.
REQ-009 funct3  in  3  RISC-V load/store funct3.
REQ-010 rs1  in  32  base address.
REQ-011 immediate  in  32  offset (I- or S-type, selected by caller).
REQ-012 rs2  in  32  store data.
REQ-013 rspValid  out  1  one-cycle completion pulse.
REQ-014 memoryOutput  out  32  load result, valid when rspValid.
REQ-015 memoryUnalignedAccess  out  1  error flag, valid when rspValid.
REQ-016 mmioInputs  in  MMIO_CHANNELS x 32  readable MMIO words.
REQ-017 mmioOutputs  out  MMIO_CHANNELS x 32  registered writable MMIO words.

Function
REQ-018 Address = rs1 + immediate, modulo 2^32; captured with rs2, funct3 and reqStore at acceptance.
REQ-019 Address bit 31 = 1 selects MMIO; 0 selects RAM, word index address[RAM_A_WIDTH+1:2], higher bits ignored (aliasing).
REQ-020 MMIO window = top 4*MMIO_CHANNELS bytes; channel = word address mod MMIO_CHANNELS. Outside the window but bit 31 set: loads return 0, stores ignored, no error.
REQ-021 Memory is little-endian: byte at offset k occupies word bits [8k+7:8k].
REQ-022 States: IDLE, READ, WRITE, RESP. reqReady = 1 only in IDLE.
REQ-023 Transitions from IDLE on acceptance:
- load: READ
- word store: WRITE
- byte/half store: READ, then WRITE (read-modify-write)
- error: RESP directly
REQ-024 READ -> RESP for loads, READ -> WRITE for sub-word stores. WRITE -> RESP. RESP -> IDLE.
REQ-025 RAM read is synchronous, 1-cycle latency; word data is captured at the end of READ.
REQ-026 Latency from acceptance edge to rspValid:
- load: 2 cycles
- word store: 2 cycles
- sub-word store: 3 cycles
- error: 1 cycle
REQ-027 Error conditions:
- half access with offset 1 or 3
- word access with offset != 0
- funct3 not in {000,001,010,100,101} for loads, not in {000,001,010} for stores
REQ-028 On error: memoryUnalignedAccess = 1 at rspValid, no RAM or MMIO write, memoryOutput = 0.
REQ-029 Load formatting:
- lb/lh: byte/half at offset, sign-extended
- lbu/lhu: zero-extended
- lw: full word
REQ-030 Store merge replaces only the addressed byte lane(s) with rs2[7:0] or rs2[15:0]; other lanes keep the READ data.
REQ-031 The RAM/MMIO write occurs only on the clock edge ending WRITE; exactly one write per store.
REQ-032 memoryOutput and memoryUnalignedAccess hold their values until the next RESP; for stores memoryOutput = 0.
REQ-033 reqValid in non-IDLE states is ignored; the request is not lost if the caller holds it until reqReady.

Reset
REQ-034 Reset assertion SHALL immediately force:
- state = IDLE
- rspValid = 0, memoryOutput = 0, memoryUnalignedAccess = 0
- all mmioOutputs = 0
REQ-035 Reset mid-operation SHALL abort with no write and no rspValid; the RAM write enable is gated by reset deasserted. RAM contents are not reset.

Structure
REQ-036 Package JZJCoreFTypes SHALL gain the state enum MemSeqState_t, the funct3 load/store constants and the MMIO base-address function of MMIO_CHANNELS.
REQ-037 One combinational sub-module, MemoryByteLaneUnit, SHALL perform load extraction/extension, store merge and alignment checking; RAM is inferred in memory_sequencer.

Verification
REQ-038 lw from 0x00000010 (RAM word 0x11223344) -> rspValid 2 cycles after acceptance, memoryOutput 0x11223344, error 0.
REQ-039 sb rs2 = 0xAB to 0x00000011 over 0x11223344 -> 3-cycle latency; subsequent lw returns 0x1122AB44; lb returns 0xFFFFFFAB, lbu returns 0x000000AB.
REQ-040 lh at 0x00000013 -> rspValid after 1 cycle, error 1, RAM unchanged; lh at 0x00000012 -> error 0, returns 0x00001122.
REQ-041 MMIO_CHANNELS = 8: sw 0xDEADBEEF to 0xFFFFFFE4 -> mmioOutputs[1] = 0xDEADBEEF; lw 0xFFFFFFFC returns mmioInputs[7]; lw 0x80000000 returns 0.
REQ-042 Reset asserted during WRITE of a sw -> target word unchanged, rspValid never pulses, all outputs 0; reqReady 1 after release.
REQ-043 reqValid held high with back-to-back requests -> one acceptance per IDLE visit; reqReady low in READ/WRITE/RESP.

Source files
------------

// File: rtl/memory_sequencer_pkg.sv
// Shared types and constants for the load/store memory sequencer.
package memory_sequencer_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } mem_seq_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Request fields captured at acceptance
  typedef struct packed {
    logic            op_store;
    logic [2:0]      op_funct3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

  // First byte address of the MMIO window occupying the top of the address space
  function automatic logic [XLEN-1:0] mmio_base(input int unsigned channels);
    return 32'(64'h1_0000_0000 - 64'(4 * channels));
  endfunction

endpackage

// File: rtl/memory_sequencer_byte_lane.sv
// Combinational byte-lane unit: load extraction/extension, store merge, access legality.
module memory_sequencer_byte_lane
  import memory_sequencer_pkg::*;
(
  input  logic            store,
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rd_word,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data_c,
  output logic [XLEN-1:0] merged_c,
  output logic            error_c,
  output logic            rmw_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        legal;
  logic        misaligned;

  always_comb begin
    byte_sel = rd_word[{offset, 3'b000} +: 8];
    half_sel = rd_word[{offset[1], 4'b0000} +: 16];

    load_data_c = '0;
    case (funct3)
      F3_LB:   load_data_c = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data_c = {{16{half_sel[15]}}, half_sel};
      F3_LW:   load_data_c = rd_word;
      F3_LBU:  load_data_c = {24'h0, byte_sel};
      F3_LHU:  load_data_c = {16'h0, half_sel};
      default: load_data_c = '0;
    endcase

    // Only the addressed lanes take store data; the rest keep the read word
    merged_c = rd_word;
    case (funct3)
      F3_SB:   merged_c[{offset, 3'b000} +: 8] = store_data[7:0];
      F3_SH:   merged_c[{offset[1], 4'b0000} +: 16] = store_data[15:0];
      F3_SW:   merged_c = store_data;
      default: merged_c = rd_word;
    endcase

    if (store) legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    else       legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                       (funct3 == F3_LBU) || (funct3 == F3_LHU);
    misaligned = ((funct3[1:0] == 2'b01) && offset[0]) ||
                 ((funct3[1:0] == 2'b10) && (offset != 2'b00));
    error_c    = !legal || misaligned;
    rmw_c      = store && (funct3 != F3_SW);
  end

endmodule

// File: rtl/memory_sequencer.sv
// RISC-V load/store sequencer over an inferred synchronous RAM and an MMIO word window.
module memory_sequencer
  import memory_sequencer_pkg::*;
#(
  parameter              INITIAL_MEM_CONTENTS = "initialRam.mem",
  parameter int unsigned RAM_A_WIDTH          = 12,
  parameter int unsigned MMIO_CHANNELS        = 8
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                reqValid,
  output logic                                reqReady,
  input  logic                                reqStore,
  input  logic [2:0]                          funct3,
  input  logic [XLEN-1:0]                     rs1,
  input  logic [XLEN-1:0]                     immediate,
  input  logic [XLEN-1:0]                     rs2,
  output logic                                rspValid,
  output logic [XLEN-1:0]                     memoryOutput,
  output logic                                memoryUnalignedAccess,
  input  logic [MMIO_CHANNELS-1:0][XLEN-1:0]  mmioInputs,
  output logic [MMIO_CHANNELS-1:0][XLEN-1:0]  mmioOutputs
);

  localparam int unsigned RAM_WORDS = 2 ** RAM_A_WIDTH;
  localparam int unsigned CH_W      = (MMIO_CHANNELS > 1) ? $clog2(MMIO_CHANNELS) : 1;
  localparam logic [XLEN-1:0] MMIO_BASE = mmio_base(MMIO_CHANNELS);

  // Preload image name is handed to the RAM macro flow, not consumed by this RTL
  if ($bits(INITIAL_MEM_CONTENTS) > 0) begin : g_preload_image
  end

  mem_seq_state_t state;
  mem_req_t       req_q;
  logic [XLEN-1:0] word_q;
  logic [XLEN-1:0] ram_q;
  logic [XLEN-1:0] ram [RAM_WORDS];

  logic [XLEN-1:0]        addr_c;
  logic [RAM_A_WIDTH-1:0] rd_idx_c;
  logic                   mmio_hit_c;
  logic [CH_W-1:0]        chan_c;
  logic [XLEN-1:0]        read_word_c;
  logic                   ram_we_c;

  logic            lane_store_c;
  logic [2:0]      lane_funct3_c;
  logic [1:0]      lane_offset_c;
  logic [XLEN-1:0] lane_word_c;
  logic [XLEN-1:0] load_data_c;
  logic [XLEN-1:0] merged_c;
  logic            error_c;
  logic            rmw_c;

  assign addr_c = rs1 + immediate;

  // Lane unit sees live request fields in IDLE, captured ones afterwards
  always_comb begin
    mmio_hit_c = (req_q.addr >= MMIO_BASE);
    chan_c     = (MMIO_CHANNELS > 1) ? CH_W'(req_q.addr >> 2) : '0;

    if (!req_q.addr[XLEN-1]) read_word_c = ram_q;
    else if (mmio_hit_c)     read_word_c = mmioInputs[chan_c];
    else                     read_word_c = '0;

    rd_idx_c = (state == IDLE) ? addr_c[RAM_A_WIDTH+1:2] : req_q.addr[RAM_A_WIDTH+1:2];
    ram_we_c = reset && (state == WRITE) && !req_q.addr[XLEN-1];

    lane_store_c  = (state == IDLE) ? reqStore : req_q.op_store;
    lane_funct3_c = (state == IDLE) ? funct3 : req_q.op_funct3;
    lane_offset_c = (state == IDLE) ? addr_c[1:0] : req_q.addr[1:0];
    lane_word_c   = (state == READ) ? read_word_c : word_q;
  end

  memory_sequencer_byte_lane u_lane (
    .store       (lane_store_c),
    .funct3      (lane_funct3_c),
    .offset      (lane_offset_c),
    .rd_word     (lane_word_c),
    .store_data  (req_q.wdata),
    .load_data_c (load_data_c),
    .merged_c    (merged_c),
    .error_c     (error_c),
    .rmw_c       (rmw_c)
  );

  // Synchronous-read RAM; contents are never reset
  always_ff @(posedge clock) begin
    if (ram_we_c) ram[req_q.addr[RAM_A_WIDTH+1:2]] <= merged_c;
    ram_q <= ram[rd_idx_c];
  end

  // Sequencer FSM with registered handshake, response and MMIO outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                 <= IDLE;
      reqReady              <= 1'b1;
      rspValid              <= 1'b0;
      memoryOutput          <= '0;
      memoryUnalignedAccess <= 1'b0;
      mmioOutputs           <= '0;
      req_q                 <= '0;
      word_q                <= '0;
    end else begin
      case (state)
        IDLE: begin
          rspValid <= 1'b0;
          if (reqValid && reqReady) begin
            req_q <= '{op_store: reqStore, op_funct3: funct3, addr: addr_c, wdata: rs2};
            reqReady <= 1'b0;
            if (error_c) begin
              state                 <= RESP;
              rspValid              <= 1'b1;
              memoryOutput          <= '0;
              memoryUnalignedAccess <= 1'b1;
            end else if (reqStore && !rmw_c) begin
              state <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          word_q <= read_word_c;
          if (req_q.op_store) begin
            state <= WRITE;
          end else begin
            state                 <= RESP;
            rspValid              <= 1'b1;
            memoryOutput          <= load_data_c;
            memoryUnalignedAccess <= 1'b0;
          end
        end
        WRITE: begin
          if (mmio_hit_c) mmioOutputs[chan_c] <= merged_c;
          state                 <= RESP;
          rspValid              <= 1'b1;
          memoryOutput          <= '0;
          memoryUnalignedAccess <= 1'b0;
        end
        RESP: begin
          rspValid <= 1'b0;
          reqReady <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          rspValid <= 1'b0;
          reqReady <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
